// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - mode-3 SPI serial-flash responder (read, JEDEC ID, status)
// sck is sampled directly in the clk domain; miso is registered one clk after each sck fall.
module spi_flash_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        spi_cs_b,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic        busy,
    output logic [23:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata
);

    localparam logic [23:0] JEDEC_ID = 24'hEF4016;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_ID,
        S_STATUS,
        S_IGNORE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sck_q;
    logic [6:0]  rx;
    logic [6:0]  tx;
    logic [7:0]  prefetch;
    logic [2:0]  bit_cnt;
    logic [1:0]  addr_cnt;
    logic [1:0]  id_idx;
    logic        fetch_cap;

    logic        rise;
    logic        fall;
    logic        byte_done;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_src;

    assign rise      = !sck_q && spi_sck && !spi_cs_b;
    assign fall      = sck_q && !spi_sck && !spi_cs_b;
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign rx_byte   = {rx, spi_mosi};

    always_comb begin
        state_next = state;
        if (spi_cs_b) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: state_next = S_CMD;
                S_CMD: begin
                    if (byte_done) begin
                        case (rx_byte)
                            8'h03:   state_next = S_ADDR;
                            8'h9F:   state_next = S_ID;
                            8'h05:   state_next = S_STATUS;
                            default: state_next = S_IGNORE;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (byte_done && (addr_cnt == 2'd2)) state_next = S_READ;
                end
                default: state_next = state;
            endcase
        end
    end

    // Byte handed to the shifter at each byte-boundary fall; 0xFF keeps miso high elsewhere.
    always_comb begin
        tx_src = 8'hFF;
        case (state)
            S_READ:   tx_src = prefetch;
            S_STATUS: tx_src = {7'b0, busy};
            S_ID: begin
                case (id_idx)
                    2'd0:    tx_src = JEDEC_ID[23:16];
                    2'd1:    tx_src = JEDEC_ID[15:8];
                    2'd2:    tx_src = JEDEC_ID[7:0];
                    default: tx_src = 8'hFF;
                endcase
            end
            default: tx_src = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            sck_q     <= 1'b1;
            spi_miso  <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= 24'h0;
            rx        <= 7'h0;
            tx        <= 7'h7F;
            prefetch  <= 8'h0;
            bit_cnt   <= 3'd0;
            addr_cnt  <= 2'd0;
            id_idx    <= 2'd0;
            fetch_cap <= 1'b0;
        end else begin
            state     <= state_next;
            sck_q     <= spi_sck;
            mem_rd    <= 1'b0;
            fetch_cap <= mem_rd;
            if (fetch_cap) prefetch <= mem_rdata;

            if (spi_cs_b) begin
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b1;
                tx       <= 7'h7F;
            end else if (state == S_IDLE) begin
                bit_cnt  <= 3'd0;
                addr_cnt <= 2'd0;
                id_idx   <= 2'd0;
            end else begin
                if (rise) begin
                    rx      <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (fall) begin
                    if (bit_cnt == 3'd0) begin
                        tx       <= tx_src[6:0];
                        spi_miso <= tx_src[7];
                        if ((state == S_ID) && (id_idx != 2'd3)) id_idx <= id_idx + 2'd1;
                        // Send the prefetched byte, then fetch the next address behind it.
                        if (state == S_READ) begin
                            mem_addr <= mem_addr + 24'd1;
                            mem_rd   <= 1'b1;
                        end
                    end else begin
                        tx       <= {tx[5:0], 1'b1};
                        spi_miso <= tx[6];
                    end
                end
                if ((state == S_ADDR) && byte_done) begin
                    case (addr_cnt)
                        2'd0:    mem_addr[23:16] <= rx_byte;
                        2'd1:    mem_addr[15:8]  <= rx_byte;
                        default: mem_addr[7:0]   <= rx_byte;
                    endcase
                    addr_cnt <= addr_cnt + 2'd1;
                    if (addr_cnt == 2'd2) mem_rd <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - directed vector bench for spi_flash_responder
module tb_spi_flash_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs_b;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;
    logic        busy;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;

    int checks = 0;
    int errors = 0;
    int rd_total = 0;
    int rd_wide = 0;
    logic rd_prev = 1'b0;

    spi_flash_responder dut (
        .clk(clk), .reset(reset), .spi_cs_b(spi_cs_b), .spi_sck(spi_sck),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: byte n holds n ^ 0x5A, one clk read latency.
    always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'h5A;

    always @(negedge clk) begin
        if (mem_rd) rd_total++;
        if (mem_rd && rd_prev) rd_wide++;
        rd_prev = mem_rd;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        spi_sck  = 1'b0;
        spi_mosi = b;
        @(negedge clk);
        @(negedge clk);
        m = spi_miso;
        spi_sck = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] o, output logic [7:0] r);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(o[i], m);
            r[i] = m;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs_b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic cs_high(input string name);
        @(negedge clk);
        spi_cs_b = 1'b1;
        @(negedge clk);
        check({name, "_miso_idle"}, {31'b0, spi_miso}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] cmd;
        int          n_cmd;
        logic        busy;
        int          n_rd;
        logic [31:0] rd_exp;
        logic [23:0] start_addr;
        logic [23:0] end_addr;
        int          exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] r;
        logic       m;
        int         rd0;

        vecs[0] = '{32'h9F000000, 1, 1'b0, 4, 32'hEF4016FF, 24'h000000, 24'h000000, 0};
        vecs[1] = '{32'h03000100, 4, 1'b0, 3, 32'h5A5B5800, 24'h000100, 24'h000103, 4};
        vecs[2] = '{32'h03FFFFFF, 4, 1'b0, 2, 32'hA55A0000, 24'hFFFFFF, 24'h000001, 3};
        vecs[3] = '{32'h05000000, 1, 1'b1, 2, 32'h01010000, 24'h000001, 24'h000001, 0};
        vecs[4] = '{32'hAB000000, 1, 1'b0, 2, 32'hFFFF0000, 24'h000001, 24'h000001, 0};

        reset = 1'b1; spi_cs_b = 1'b1; spi_sck = 1'b1; spi_mosi = 1'b0; busy = 1'b0;
        #1;
        check("rst_miso", {31'b0, spi_miso}, 32'd1);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("rst_mem_addr", {8'b0, mem_addr}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            busy = vecs[v].busy;
            rd0 = rd_total;
            cs_low();
            for (int k = 0; k < vecs[v].n_cmd; k++) begin
                spi_byte(vecs[v].cmd[31-8*k -: 8], r);
                check($sformatf("v%0d_cmd%0d_miso", v, k), {24'b0, r}, 32'hFF);
            end
            check($sformatf("v%0d_start_addr", v), {8'b0, mem_addr}, {8'b0, vecs[v].start_addr});
            for (int j = 0; j < vecs[v].n_rd; j++) begin
                spi_byte(8'h00, r);
                check($sformatf("v%0d_byte%0d", v, j), {24'b0, r}, {24'b0, vecs[v].rd_exp[31-8*j -: 8]});
            end
            cs_high($sformatf("v%0d", v));
            check($sformatf("v%0d_end_addr", v), {8'b0, mem_addr}, {8'b0, vecs[v].end_addr});
            check($sformatf("v%0d_rd_count", v), rd_total - rd0, vecs[v].exp_rd);
        end
        check("rd_width", rd_wide, 0);

        // Busy sampled at the byte-boundary fall: dropping it mid-byte affects the next byte.
        busy = 1'b1;
        cs_low();
        spi_byte(8'h05, r);
        spi_byte(8'h00, r);
        check("stat_b1", {24'b0, r}, 32'h01);
        for (int i = 7; i >= 0; i--) begin
            spi_bit(1'b0, m);
            r[i] = m;
            if (i == 4) busy = 1'b0;
        end
        check("stat_b2", {24'b0, r}, 32'h01);
        spi_byte(8'h00, r);
        check("stat_b3", {24'b0, r}, 32'h00);
        cs_high("stat");

        // Abort after 4 bits of the second address byte.
        rd0 = rd_total;
        cs_low();
        spi_byte(8'h03, r);
        spi_byte(8'h12, r);
        for (int i = 7; i >= 4; i--) spi_bit(i[0], m);
        cs_high("abort_addr");
        check("abort_addr_hold", {8'b0, mem_addr}, 32'h120001);
        check("abort_no_rd", rd_total - rd0, 0);

        // Fresh ID read, then abort mid data byte while miso is low.
        cs_low();
        spi_byte(8'h9F, r);
        spi_byte(8'h00, r);
        check("id_after_abort", {24'b0, r}, 32'hEF);
        r = 8'h00;
        for (int i = 7; i >= 4; i--) begin
            spi_bit(1'b0, m);
            r[i] = m;
        end
        check("id_partial", {24'b0, r}, 32'h40);
        check("id_partial_miso", {31'b0, spi_miso}, 32'd0);
        cs_high("abort_id");

        // Async reset mid-READ: first data bit from 0x10 is 0 (0x4A).
        cs_low();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_byte(8'h10, r);
        spi_bit(1'b0, m);
        check("rd_pre_reset_bit", {31'b0, m}, 32'd0);
        check("rd_pre_reset_addr", {8'b0, mem_addr}, 32'h000011);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_miso", {31'b0, spi_miso}, 32'd1);
        check("async_rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        check("async_rst_addr", {8'b0, mem_addr}, 32'd0);
        spi_cs_b = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rd_width_final", rd_wide, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
